// File: rtl/comm_slave_if.sv
// Command-link slave bus: serial pins plus the consumer-side command and response handshakes.
interface comm_slave_if;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        snd_resp;
  logic        tx_busy;
  logic        resp_sent;
  logic        frm_err;

  modport slave (
    input  RX, clr_cmd_rdy, resp, snd_resp,
    output TX, cmd, cmd_rdy, tx_busy, resp_sent, frm_err
  );

  modport master (
    output RX, clr_cmd_rdy, resp, snd_resp,
    input  TX, cmd, cmd_rdy, tx_busy, resp_sent, frm_err
  );
endinterface

// File: rtl/comm_slave.sv
// Remote end of the two-byte UART command link: 8N1 receiver, two-byte command
// assembly with an inter-byte timeout, and an 8N1 one-byte response transmitter.
module comm_slave #(
  parameter int BAUD_DIV = 2604,
  parameter int TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        rst,
  comm_slave_if.slave bus
);
  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_LAST = 12'((BAUD_DIV / 2) - 1);
  localparam logic [15:0] TO_LIMIT  = 16'(TIMEOUT);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {WAIT_HIGH, WAIT_LOW} asm_state_t;
  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_t   rx_state_q, rx_state_d;
  logic [11:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        frm_err_q, frm_err_d;
  logic        byte_vld;
  logic        start_edge;

  asm_state_t  asm_q, asm_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;

  tx_state_t   tx_state_q, tx_state_d;
  logic [9:0]  tx_shift_q, tx_shift_d;
  logic [11:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        sent_q, sent_d;

  // Two-flop synchroniser plus edge register; all preset to the idle line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= bus.RX;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign start_edge = rx_prev_q & ~rx_s2_q;

  // Receiver next state: half-bit start check, eight mid-bit samples LSB first, stop check.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_vld   = 1'b0;
    frm_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (start_edge) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 12'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 12'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_state_d = RX_IDLE;
          byte_vld   = rx_s2_q;
          frm_err_d  = ~rx_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 12'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receiver control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      frm_err_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      frm_err_q  <= frm_err_d;
    end
  end

  // Assembly next state: high byte, then low byte before the idle-time budget runs out.
  always_comb begin
    asm_d     = asm_q;
    hi_d      = hi_q;
    to_cnt_d  = to_cnt_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    if (bus.clr_cmd_rdy) cmd_rdy_d = 1'b0;
    case (asm_q)
      WAIT_HIGH: begin
        if (byte_vld) begin
          hi_d     = rx_shift_q;
          to_cnt_d = '0;
          asm_d    = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (byte_vld) begin
          cmd_d     = {hi_q, rx_shift_q};
          cmd_rdy_d = 1'b1;
          asm_d     = WAIT_HIGH;
        end else if (frm_err_d || (to_cnt_q == TO_LIMIT)) begin
          asm_d = WAIT_HIGH;
        end else if (rx_state_q == RX_IDLE) begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      default: asm_d = WAIT_HIGH;
    endcase
  end

  // Assembly control and command output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q     <= WAIT_HIGH;
      to_cnt_q  <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      asm_q     <= asm_d;
      to_cnt_q  <= to_cnt_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  // Transmitter next state: load {stop, resp, start}, shift one bit per baud period.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    sent_d     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (bus.snd_resp) begin
          tx_shift_d = {1'b1, bus.resp, 1'b0};
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if (tx_cnt_q == BAUD_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_state_d = TX_IDLE;
            tx_d       = 1'b1;
            busy_d     = 1'b0;
            sent_d     = 1'b1;
          end else begin
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
            tx_d       = tx_shift_q[1];
            tx_bit_d   = tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 12'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Transmitter control and line registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      sent_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      sent_q     <= sent_d;
    end
  end

  // Data-only registers; their contents are only used once control qualifies them.
  always_ff @(posedge clk) begin
    rx_shift_q <= rx_shift_d;
    hi_q       <= hi_d;
    tx_shift_q <= tx_shift_d;
  end

  assign bus.TX        = tx_q;
  assign bus.cmd       = cmd_q;
  assign bus.cmd_rdy   = cmd_rdy_q;
  assign bus.tx_busy   = busy_q;
  assign bus.resp_sent = sent_q;
  assign bus.frm_err   = frm_err_q;
endmodule

// File: tb/tb_comm_slave.sv
// Bench for comm_slave: directed link scenarios plus a randomized frame stream
// checked against a byte-level model of the command assembly rules.
`timescale 1ns/1ps
module tb_comm_slave;
  localparam int BD = 16;
  localparam int TO = 400;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_frm = 0, n_sent = 0, n_rise = 0;
  int   rise_cyc = 0, sent_cyc = 0;
  logic rdy_prev = 1'b0;

  comm_slave_if bus();

  comm_slave #(.BAUD_DIV(BD), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.frm_err) n_frm <= n_frm + 1;
    if (bus.resp_sent) begin
      n_sent   <= n_sent + 1;
      sent_cyc <= cyc;
    end
    if (bus.cmd_rdy && !rdy_prev) begin
      n_rise   <= n_rise + 1;
      rise_cyc <= cyc;
    end
    rdy_prev <= bus.cmd_rdy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic clr_pulse();
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok, output int st);
    st = cyc;
    bus.RX = 1'b0;
    idle(BD);
    for (int i = 0; i < 8; i++) begin
      bus.RX = b[i];
      idle(BD);
    end
    bus.RX = stop_ok;
    idle(BD);
    bus.RX = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    total++; if (bus.TX !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", bus.TX); end
    total++; if (bus.cmd !== 16'h0000) begin bad++; $display("FAIL reset_cmd got=%h want=0000", bus.cmd); end
    total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL reset_cmd_rdy got=%b want=0", bus.cmd_rdy); end
    total++; if (bus.tx_busy !== 1'b0) begin bad++; $display("FAIL reset_tx_busy got=%b want=0", bus.tx_busy); end
    total++; if ({bus.resp_sent, bus.frm_err} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b want=00", {bus.resp_sent, bus.frm_err}); end
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_back_to_back();
    int st, r0, d;
    r0 = n_rise;
    send_frame(8'hA5, 1'b1, st);
    send_frame(8'h3C, 1'b1, st);
    idle(1);
    d = rise_cyc - st;
    total++; if (n_rise - r0 != 1) begin bad++; $display("FAIL b2b_rises got=%0d want=1", n_rise - r0); end
    total++; if (d < 152 || d > 158) begin bad++; $display("FAIL b2b_latency got=%0d want=152..158", d); end
    total++; if (bus.cmd !== 16'hA53C) begin bad++; $display("FAIL b2b_cmd got=%h want=a53c", bus.cmd); end
    total++; if (bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL b2b_rdy got=%b want=1", bus.cmd_rdy); end
    clr_pulse();
    total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL b2b_clr got=%b want=0", bus.cmd_rdy); end
    idle(10);
  endtask

  task automatic test_timeout();
    int st;
    send_frame(8'h12, 1'b1, st);
    idle(500);
    send_frame(8'h34, 1'b1, st);
    idle(4);
    total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL to_discard got=%b want=0", bus.cmd_rdy); end
    send_frame(8'h56, 1'b1, st);
    idle(4);
    total++; if (bus.cmd !== 16'h3456) begin bad++; $display("FAIL to_cmd got=%h want=3456", bus.cmd); end
    total++; if (bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL to_rdy got=%b want=1", bus.cmd_rdy); end
    clr_pulse();
    idle(10);
  endtask

  task automatic test_frame_err();
    int st, f0;
    f0 = n_frm;
    send_frame(8'h77, 1'b0, st);
    idle(4);
    total++; if (n_frm - f0 != 1) begin bad++; $display("FAIL ferr_count got=%0d want=1", n_frm - f0); end
    total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL ferr_rdy got=%b want=0", bus.cmd_rdy); end
    send_frame(8'h01, 1'b1, st);
    idle(4);
    total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL ferr_hi_only got=%b want=0", bus.cmd_rdy); end
    send_frame(8'h02, 1'b1, st);
    idle(4);
    total++; if (bus.cmd !== 16'h0102 || bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL ferr_cmd got=%h/%b want=0102/1", bus.cmd, bus.cmd_rdy); end
    clr_pulse();
    idle(10);
  endtask

  task automatic test_glitch();
    int st, f0, r0;
    f0 = n_frm;
    r0 = n_rise;
    bus.RX = 1'b0;
    idle(4);
    bus.RX = 1'b1;
    idle(30);
    send_frame(8'hFF, 1'b1, st);
    send_frame(8'h00, 1'b1, st);
    idle(4);
    total++; if (bus.cmd !== 16'hFF00) begin bad++; $display("FAIL glitch_cmd got=%h want=ff00", bus.cmd); end
    total++; if (n_rise - r0 != 1 || n_frm != f0) begin bad++; $display("FAIL glitch_events got=%0d/%0d want=1/0", n_rise - r0, n_frm - f0); end
    clr_pulse();
    idle(10);
  endtask

  task automatic test_tx();
    logic [9:0] fr;
    int k, s0, d;
    fr = {1'b1, 8'hC3, 1'b0};
    s0 = n_sent;
    bus.resp = 8'hC3;
    bus.snd_resp = 1'b1;
    tick();
    bus.snd_resp = 1'b0;
    k = cyc;
    for (int t = 1; t <= 200; t++) begin
      if (t == 30) begin
        bus.resp = 8'h11;
        bus.snd_resp = 1'b1;
      end
      tick();
      bus.snd_resp = 1'b0;
      if ((t % 16) == 8 && t < 160) begin
        total++; if (bus.TX !== fr[t / 16]) begin bad++; $display("FAIL tx_bit%0d got=%b want=%b", t / 16, bus.TX, fr[t / 16]); end
      end
      if (t == 100) begin
        total++; if (bus.tx_busy !== 1'b1) begin bad++; $display("FAIL tx_busy_mid got=%b want=1", bus.tx_busy); end
      end
    end
    d = sent_cyc - k;
    total++; if (n_sent - s0 != 1) begin bad++; $display("FAIL tx_sent_count got=%0d want=1", n_sent - s0); end
    total++; if (d < 158 || d > 163) begin bad++; $display("FAIL tx_sent_time got=%0d want=158..163", d); end
    total++; if (bus.tx_busy !== 1'b0 || bus.TX !== 1'b1) begin bad++; $display("FAIL tx_end got=%b/%b want=0/1", bus.tx_busy, bus.TX); end
  endtask

  task automatic test_set_priority();
    int st, r0;
    r0 = n_rise;
    send_frame(8'hBE, 1'b1, st);
    bus.clr_cmd_rdy = 1'b1;
    send_frame(8'hEF, 1'b1, st);
    idle(4);
    bus.clr_cmd_rdy = 1'b0;
    total++; if (n_rise - r0 != 1) begin bad++; $display("FAIL prio_set got=%0d want=1", n_rise - r0); end
    total++; if (bus.cmd !== 16'hBEEF) begin bad++; $display("FAIL prio_cmd got=%h want=beef", bus.cmd); end
    total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL prio_later_clr got=%b want=0", bus.cmd_rdy); end
    idle(10);
  endtask

  task automatic test_reset_mid();
    int f0, s0;
    bus.resp = 8'h00;
    bus.snd_resp = 1'b1;
    tick();
    bus.snd_resp = 1'b0;
    bus.RX = 1'b0;
    idle(40);
    total++; if (bus.TX !== 1'b0) begin bad++; $display("FAIL rmid_pre_tx got=%b want=0", bus.TX); end
    #3;
    rst = 1'b1;
    #1;
    total++; if (bus.TX !== 1'b1 || bus.tx_busy !== 1'b0) begin bad++; $display("FAIL rmid_tx got=%b/%b want=1/0", bus.TX, bus.tx_busy); end
    total++; if (bus.cmd !== 16'h0000 || bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL rmid_cmd got=%h/%b want=0000/0", bus.cmd, bus.cmd_rdy); end
    bus.RX = 1'b1;
    idle(3);
    rst = 1'b0;
    f0 = n_frm;
    s0 = n_sent;
    idle(300);
    total++; if (n_frm != f0 || n_sent != s0) begin bad++; $display("FAIL rmid_pulses got=%0d/%0d want=0/0", n_frm - f0, n_sent - s0); end
  endtask

  task automatic test_random();
    logic [7:0]  b, hi;
    logic [15:0] last_cmd, exp_cmd;
    logic        ok, big, pend, fresh;
    int          gap, st, f0, exp_frm;
    last_cmd = 16'h0000;
    hi = 8'h00;
    pend = 1'b0;
    for (int n = 0; n < 14; n++) begin
      b   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 5) != 0);
      big = ($urandom_range(0, 3) == 0);
      gap = big ? int'($urandom_range(450, 600)) : int'($urandom_range(0, 60));
      idle(gap);
      if (big) pend = 1'b0;
      fresh = 1'b0;
      exp_frm = 0;
      exp_cmd = last_cmd;
      if (!ok) begin
        exp_frm = 1;
        pend = 1'b0;
      end else if (pend) begin
        exp_cmd = {hi, b};
        fresh = 1'b1;
        pend = 1'b0;
      end else begin
        hi = b;
        pend = 1'b1;
      end
      f0 = n_frm;
      send_frame(b, ok, st);
      idle(4);
      total++; if (n_frm - f0 != exp_frm) begin bad++; $display("FAIL rnd%0d_frm got=%0d want=%0d", n, n_frm - f0, exp_frm); end
      total++; if (bus.cmd_rdy !== fresh) begin bad++; $display("FAIL rnd%0d_rdy got=%b want=%b", n, bus.cmd_rdy, fresh); end
      total++; if (bus.cmd !== exp_cmd) begin bad++; $display("FAIL rnd%0d_cmd got=%h want=%h", n, bus.cmd, exp_cmd); end
      last_cmd = exp_cmd;
      clr_pulse();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.RX = 1'b1;
    bus.clr_cmd_rdy = 1'b0;
    bus.resp = 8'h00;
    bus.snd_resp = 1'b0;
    test_reset();
    test_back_to_back();
    test_timeout();
    test_frame_err();
    test_glitch();
    test_tx();
    test_set_priority();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
